// File: rtl/maindec_pipe_if.sv
// Decode/pipeline bus between the IF/ID register, maindec_pipe and the datapath stage registers.
// The illegal-instruction signals exist only when MAINDEC_ILLEGAL_EXC_EN is defined.
interface maindec_pipe_if #(
   parameter int STAGES = 3
);
   logic                  id_valid;
   logic [31:0]           id_instr;
   logic                  hz_stall;
   logic [13:0]           id_ctrl;
   logic                  id_ready;
   logic [14*STAGES-1:0]  ctrl_pipe;
   logic [STAGES-1:0]     valid_pipe;
   logic                  md_busy;
   logic                  md_start;
   logic                  md_done;

`ifdef MAINDEC_ILLEGAL_EXC_EN
   logic                  id_illegal;
   logic [5:0]            exc_op;
   logic                  exc_flag;

   modport master (
      output id_valid, id_instr, hz_stall,
      input  id_ctrl, id_ready, ctrl_pipe, valid_pipe, md_busy, md_start, md_done,
             id_illegal, exc_op, exc_flag
   );

   modport slave (
      input  id_valid, id_instr, hz_stall,
      output id_ctrl, id_ready, ctrl_pipe, valid_pipe, md_busy, md_start, md_done,
             id_illegal, exc_op, exc_flag
   );
`else
   modport master (
      output id_valid, id_instr, hz_stall,
      input  id_ctrl, id_ready, ctrl_pipe, valid_pipe, md_busy, md_start, md_done
   );

   modport slave (
      input  id_valid, id_instr, hz_stall,
      output id_ctrl, id_ready, ctrl_pipe, valid_pipe, md_busy, md_start, md_done
   );
`endif
endinterface

// File: rtl/maindec_pipe.sv
// Pipelined main decoder: op/funct -> 14-bit control word, STAGES-deep valid-tagged control pipe,
// and a mult/div busy timer that interlocks HI/LO users in ID. Optional macro: MAINDEC_ILLEGAL_EXC_EN.
module maindec_pipe #(
   parameter int STAGES     = 3,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic          clk,
   input  logic          rst,
   maindec_pipe_if.slave bus
);
   localparam logic [3:0] USELESS_OP = 4'd0;
   localparam logic [3:0] R_TYPE_OP  = 4'd1;
   localparam logic [3:0] MEM_OP     = 4'd2;
   localparam logic [3:0] ADDI_OP    = 4'd3;
   localparam logic [3:0] ADDIU_OP   = 4'd4;
   localparam logic [3:0] ANDI_OP    = 4'd5;
   localparam logic [3:0] ORI_OP     = 4'd6;
   localparam logic [3:0] XORI_OP    = 4'd7;
   localparam logic [3:0] LUI_OP     = 4'd8;
   localparam logic [3:0] SLTI_OP    = 4'd9;
   localparam logic [3:0] SLTIU_OP   = 4'd10;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   localparam logic [9:0] IMM_CTRL = 10'b1010000000;

   // The md_start cycle is the first busy cycle, so BUSY covers CYCLES-1 cycles ending at cnt==0.
   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CW-1:0] MUL_LOAD = CW'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
   localparam logic [CW-1:0] DIV_LOAD = CW'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);
   localparam bit MUL_SINGLE = (MUL_CYCLES <= 1);
   localparam bit DIV_SINGLE = (DIV_CYCLES <= 1);

   typedef enum logic {IDLE, BUSY} state_t;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic        rtype;
   logic [9:0]  upper;
   logic [3:0]  aluop;
   logic [13:0] ctrl_id;
   logic        hilo_user;
   logic        id_ready;
   logic        illegal;
   logic        slot0_take;

   logic [13:0]         ctrl_q [STAGES];
   logic [STAGES-1:0]   valid_q;
   logic [5:0]          funct0_q;
   logic [14*STAGES-1:0] ctrl_flat;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          md_start;
   logic          md_busy;
   logic          done_c;
   logic          slot0_is_mul;
   logic          slot0_is_div;

   logic unused_instr_bits;

   assign op    = bus.id_instr[31:26];
   assign funct = bus.id_instr[5:0];
   assign rtype = (op == OP_RTYPE);
   assign unused_instr_bits = ^bus.id_instr[25:6];

   always_comb begin
      upper = 10'b0;
      aluop = USELESS_OP;
      case (op)
         OP_RTYPE: begin
            aluop = R_TYPE_OP;
            case (funct)
               F_MTHI:                         upper = 10'b0000000010;
               F_MTLO:                         upper = 10'b0000000001;
               F_MULT, F_MULTU, F_DIV, F_DIVU: upper = 10'b0000000011;
               default:                        upper = 10'b1100000000;
            endcase
         end
         OP_ADDI:  begin upper = IMM_CTRL;      aluop = ADDI_OP;  end
         OP_ADDIU: begin upper = IMM_CTRL;      aluop = ADDIU_OP; end
         OP_SLTI:  begin upper = IMM_CTRL;      aluop = SLTI_OP;  end
         OP_SLTIU: begin upper = IMM_CTRL;      aluop = SLTIU_OP; end
         OP_ANDI:  begin upper = IMM_CTRL;      aluop = ANDI_OP;  end
         OP_ORI:   begin upper = IMM_CTRL;      aluop = ORI_OP;   end
         OP_XORI:  begin upper = IMM_CTRL;      aluop = XORI_OP;  end
         OP_LUI:   begin upper = IMM_CTRL;      aluop = LUI_OP;   end
         OP_LW:    begin upper = 10'b1001001000; aluop = MEM_OP;  end
         OP_SW:    begin upper = 10'b0001010000; aluop = MEM_OP;  end
         OP_BEQ:   begin upper = 10'b0000100000; aluop = USELESS_OP; end
         OP_J:     begin upper = 10'b0000000100; aluop = USELESS_OP; end
         default:  ;
      endcase
   end

   assign ctrl_id   = {upper, aluop};
   assign hilo_user = (ctrl_id[5:4] != 2'b00) | (rtype & ((funct == F_MFHI) | (funct == F_MFLO)));
   assign id_ready  = ~bus.hz_stall & ~(bus.id_valid & hilo_user & (md_busy | md_start));

`ifdef MAINDEC_ILLEGAL_EXC_EN
   logic       op_known;
   logic       funct_known;
   logic [5:0] exc_op_q;
   logic       exc_flag_q;

   always_comb begin
      op_known = 1'b0;
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: op_known = 1'b1;
         default: ;
      endcase
      funct_known = 1'b0;
      case (funct)
         6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
         F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU,
         6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
         6'b100110, 6'b100111, 6'b101010, 6'b101011: funct_known = 1'b1;
         default: ;
      endcase
   end

   assign illegal = bus.id_valid & (~op_known | (rtype & ~funct_known));

   // First illegal instruction that actually leaves ID is latched until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         exc_op_q   <= 6'b0;
         exc_flag_q <= 1'b0;
      end else if (illegal & id_ready & ~exc_flag_q) begin
         exc_op_q   <= op;
         exc_flag_q <= 1'b1;
      end
   end

   assign bus.id_illegal = illegal;
   assign bus.exc_op     = exc_op_q;
   assign bus.exc_flag   = exc_flag_q;
`else
   assign illegal = 1'b0;
`endif

   assign slot0_take = id_ready & ~illegal;

   // Stalls and illegal instructions enter slot 0 as a full bubble; later slots always shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= 14'b0;
         end
         valid_q  <= '0;
         funct0_q <= 6'b0;
      end else begin
         ctrl_q[0]  <= slot0_take ? ctrl_id : 14'b0;
         valid_q[0] <= bus.id_valid & slot0_take;
         funct0_q   <= (slot0_take & rtype) ? funct : 6'b0;
         for (int k = 1; k < STAGES; k++) begin
            ctrl_q[k]  <= ctrl_q[k-1];
            valid_q[k] <= valid_q[k-1];
         end
      end
   end

   always_comb begin
      ctrl_flat = '0;
      for (int k = 0; k < STAGES; k++) begin
         ctrl_flat[14*k +: 14] = ctrl_q[k];
      end
   end

   assign slot0_is_mul = (funct0_q == F_MULT) | (funct0_q == F_MULTU);
   assign slot0_is_div = (funct0_q == F_DIV)  | (funct0_q == F_DIVU);
   assign md_start     = valid_q[0] & (slot0_is_mul | slot0_is_div);
   assign md_busy      = (state == BUSY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      done_c     = 1'b0;
      case (state)
         IDLE: begin
            if (md_start) begin
               if ((slot0_is_mul & MUL_SINGLE) | (slot0_is_div & DIV_SINGLE)) begin
                  done_c = 1'b1;
               end else begin
                  state_next = BUSY;
                  cnt_next   = slot0_is_div ? DIV_LOAD : MUL_LOAD;
               end
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               done_c     = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt - CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.id_ctrl    = ctrl_id;
   assign bus.id_ready   = id_ready;
   assign bus.ctrl_pipe  = ctrl_flat;
   assign bus.valid_pipe = valid_q;
   assign bus.md_busy    = md_busy;
   assign bus.md_start   = md_start;
   assign bus.md_done    = done_c & ~rst;
endmodule

// File: tb/tb_maindec_pipe.sv
// Self-checking bench for maindec_pipe: directed scenarios plus randomized traffic against a
// cycle-indexed reference model of decode, pipeline slots and mult/div busy windows.
module tb_maindec_pipe;
   localparam int STAGES     = 3;
   localparam int MUL_CYCLES = 4;
   localparam int DIV_CYCLES = 32;

   localparam logic [3:0] A_USELESS = 4'd0;
   localparam logic [3:0] A_RTYPE   = 4'd1;
   localparam logic [3:0] A_MEM     = 4'd2;
   localparam logic [3:0] A_ADDI    = 4'd3;
   localparam logic [3:0] A_ADDIU   = 4'd4;
   localparam logic [3:0] A_ANDI    = 4'd5;
   localparam logic [3:0] A_ORI     = 4'd6;
   localparam logic [3:0] A_XORI    = 4'd7;
   localparam logic [3:0] A_LUI     = 4'd8;
   localparam logic [3:0] A_SLTI    = 4'd9;
   localparam logic [3:0] A_SLTIU   = 4'd10;

   localparam logic [31:0] I_LW    = 32'h8C010004;
   localparam logic [31:0] I_SW    = 32'hAC010004;
   localparam logic [31:0] I_DIV   = 32'h0000001A;
   localparam logic [31:0] I_MFLO  = 32'h00000012;
   localparam logic [31:0] I_MULT  = 32'h00000018;
   localparam logic [31:0] I_ADDIU = 32'h24210001;
   localparam logic [31:0] I_BAD   = 32'hFC000000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   maindec_pipe_if #(.STAGES(STAGES)) bus ();

   maindec_pipe #(
      .STAGES(STAGES), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [13:0]       mCtrl [STAGES];
   logic [STAGES-1:0] mValid;
   int                mCycles0;
   int                cyc;
   int                startCyc;
   int                busyEnd;
   bit                modelKnown;
   logic              mExcFlag;
   logic [5:0]        mExcOp;

   logic        curValid, curStall, curRst;
   logic [31:0] curInstr;
   logic [13:0] eCtrl;
   logic        eReady, eStart, eBusy, eDone, eIllegal;
   logic [14*STAGES-1:0] eFlat;

   logic [31:0] rIns;
   int stalls, startAt, doneAt, busyCount;
   logic sawReady, sawDone;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [13:0] refDecode(input logic [31:0] ins);
      logic [5:0] op, fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'b000000) begin
         if (fn == 6'b010001) return {10'b0000000010, A_RTYPE};
         if (fn == 6'b010011) return {10'b0000000001, A_RTYPE};
         if (fn inside {6'b011000, 6'b011001, 6'b011010, 6'b011011})
            return {10'b0000000011, A_RTYPE};
         return {10'b1100000000, A_RTYPE};
      end
      case (op)
         6'b001000: return {10'b1010000000, A_ADDI};
         6'b001001: return {10'b1010000000, A_ADDIU};
         6'b001010: return {10'b1010000000, A_SLTI};
         6'b001011: return {10'b1010000000, A_SLTIU};
         6'b001100: return {10'b1010000000, A_ANDI};
         6'b001101: return {10'b1010000000, A_ORI};
         6'b001110: return {10'b1010000000, A_XORI};
         6'b001111: return {10'b1010000000, A_LUI};
         6'b100011: return {10'b1001001000, A_MEM};
         6'b101011: return {10'b0001010000, A_MEM};
         6'b000100: return {10'b0000100000, A_USELESS};
         6'b000010: return {10'b0000000100, A_USELESS};
         default:   return 14'b0;
      endcase
   endfunction

   function automatic int mdCycles(input logic [31:0] ins);
      if (ins[31:26] != 6'b000000) return 0;
      if (ins[5:0] inside {6'b011000, 6'b011001}) return MUL_CYCLES;
      if (ins[5:0] inside {6'b011010, 6'b011011}) return DIV_CYCLES;
      return 0;
   endfunction

   function automatic bit hiloUser(input logic [31:0] ins);
      logic [13:0] c;
      c = refDecode(ins);
      return (c[5:4] != 2'b00) || (ins[31:26] == 6'b000000 && ins[5:0] inside {6'b010000, 6'b010010});
   endfunction

`ifdef MAINDEC_ILLEGAL_EXC_EN
   function automatic bit isLegal(input logic [31:0] ins);
      if (ins[31:26] == 6'b000000)
         return ins[5:0] inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7,
                                 [6'b010000:6'b010011], [6'b011000:6'b011011],
                                 [6'b100000:6'b100111], 6'b101010, 6'b101011};
      return ins[31:26] inside {6'b000010, 6'b000100, [6'b001000:6'b001111], 6'b100011, 6'b101011};
   endfunction
`endif

   function automatic logic [31:0] randInstr();
      logic [31:0] ins;
      int sel;
      ins = $urandom;
      sel = $urandom_range(11);
      case (sel)
         0: begin ins[31:26] = 6'b0; ins[5:0] = {5'b01100, 1'($urandom_range(1))}; end
         1: begin ins[31:26] = 6'b0; ins[5:0] = {5'b01101, 1'($urandom_range(1))}; end
         2: begin ins[31:26] = 6'b0; ins[5:0] = {4'b0100, 1'($urandom_range(1)), 1'b0}; end
         3: begin ins[31:26] = 6'b0; ins[5:0] = {4'b0100, 1'($urandom_range(1)), 1'b1}; end
         4: ins[31:26] = 6'b0;
         5, 6: ins[31:26] = {3'b001, 3'($urandom_range(7))};
         7: ins[31:26] = 6'b100011;
         8: ins[31:26] = 6'b101011;
         9: ins[31:26] = 6'b000100;
         10: ins[31:26] = 6'b000010;
         default: ;
      endcase
      return ins;
   endfunction

   // Drives one ID cycle at the falling edge and compares every output against the model.
   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic st, input logic r);
      @(negedge clk);
      bus.id_valid = v;
      bus.id_instr = ins;
      bus.hz_stall = st;
      rst          = r;
      curValid = v; curInstr = ins; curStall = st; curRst = r;
      #1;
      eCtrl  = refDecode(ins);
      eStart = mValid[0] && (mCycles0 != 0);
      eBusy  = (cyc > startCyc) && (cyc <= busyEnd);
      eDone  = !r && ((eStart && mCycles0 == 1) || (eBusy && cyc == busyEnd));
      eReady = !st && !(v && hiloUser(ins) && (eBusy || eStart));
`ifdef MAINDEC_ILLEGAL_EXC_EN
      eIllegal = v && !isLegal(ins);
`else
      eIllegal = 1'b0;
`endif
      for (int k = 0; k < STAGES; k++) eFlat[14*k +: 14] = mCtrl[k];
      if (modelKnown) begin
         checkOutput("id_ctrl", 64'(bus.id_ctrl), 64'(eCtrl));
         checkOutput("id_ready", 64'(bus.id_ready), 64'(eReady));
         checkOutput("md_start", 64'(bus.md_start), 64'(eStart));
         checkOutput("md_busy", 64'(bus.md_busy), 64'(eBusy));
         checkOutput("md_done", 64'(bus.md_done), 64'(eDone));
         checkOutput("ctrl_pipe", 64'(bus.ctrl_pipe), 64'(eFlat));
         checkOutput("valid_pipe", 64'(bus.valid_pipe), 64'(mValid));
`ifdef MAINDEC_ILLEGAL_EXC_EN
         checkOutput("id_illegal", 64'(bus.id_illegal), 64'(eIllegal));
         checkOutput("exc_op", 64'(bus.exc_op), 64'(mExcOp));
         checkOutput("exc_flag", 64'(bus.exc_flag), 64'(mExcFlag));
`endif
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (curRst) begin
         for (int k = 0; k < STAGES; k++) mCtrl[k] = 14'b0;
         mValid = '0; mCycles0 = 0; startCyc = -1; busyEnd = -1;
         mExcFlag = 1'b0; mExcOp = 6'b0; modelKnown = 1'b1;
      end else begin
         if (eStart) begin
            startCyc = cyc;
            busyEnd  = cyc + mCycles0 - 1;
         end
         for (int k = STAGES - 1; k > 0; k--) begin
            mCtrl[k]  = mCtrl[k-1];
            mValid[k] = mValid[k-1];
         end
         if (eReady && !eIllegal) begin
            mCtrl[0] = eCtrl; mValid[0] = curValid; mCycles0 = mdCycles(curInstr);
         end else begin
            mCtrl[0] = 14'b0; mValid[0] = 1'b0; mCycles0 = 0;
         end
         if (eIllegal && eReady && !mExcFlag) begin
            mExcFlag = 1'b1;
            mExcOp   = curInstr[31:26];
         end
      end
      cyc++;
   endtask

   initial begin
      modelKnown = 1'b0; cyc = 0; startCyc = -1; busyEnd = -1; mCycles0 = 0;
      mValid = '0; mExcFlag = 1'b0; mExcOp = 6'b0;
      for (int k = 0; k < STAGES; k++) mCtrl[k] = 14'b0;
      bus.id_valid = 1'b0; bus.id_instr = 32'b0; bus.hz_stall = 1'b0; rst = 1'b1;

      applyStimulus(1'b0, 32'b0, 1'b0, 1'b1); advance();
      applyStimulus(1'b0, 32'b0, 1'b0, 1'b1); advance();
      applyStimulus(1'b0, 32'b0, 1'b0, 1'b0);
      checkOutput("reset_valid", 64'(bus.valid_pipe), 64'd0);
      checkOutput("reset_ctrl", 64'(bus.ctrl_pipe), 64'd0);
      checkOutput("reset_busy", 64'(bus.md_busy), 64'd0);
      advance();

      // LW flows to slot 2 three cycles after issue
      applyStimulus(1'b1, I_LW, 1'b0, 1'b0);
      checkOutput("lw_upper", 64'(bus.id_ctrl[13:4]), 64'(10'b1001001000));
      advance();
      applyStimulus(1'b0, 32'b0, 1'b0, 1'b0);
      checkOutput("lw_slot0_valid", 64'(bus.valid_pipe[0]), 64'd1);
      advance();
      applyStimulus(1'b0, 32'b0, 1'b0, 1'b0); advance();
      applyStimulus(1'b0, 32'b0, 1'b0, 1'b0);
      checkOutput("lw_slot2_valid", 64'(bus.valid_pipe[2]), 64'd1);
      checkOutput("lw_slot2_ctrl", 64'(bus.ctrl_pipe[41:28]), 64'({10'b1001001000, A_MEM}));
      advance();

      // DIV followed by a dependent MFLO
      applyStimulus(1'b1, I_DIV, 1'b0, 1'b0); advance();
      stalls = 0; startAt = -1; doneAt = -1; sawReady = 1'b0;
      for (int i = 0; i < 100 && !sawReady; i++) begin
         applyStimulus(1'b1, I_MFLO, 1'b0, 1'b0);
         if (bus.md_start === 1'b1 && startAt < 0) startAt = i + 1;
         if (bus.md_done === 1'b1 && doneAt < 0) doneAt = i + 1;
         sawReady = (bus.id_ready === 1'b1);
         if (!sawReady) stalls++;
         advance();
      end
      checkOutput("div_mflo_accepted", 64'(sawReady), 64'd1);
      checkOutput("div_start_cycle", 64'(startAt), 64'd1);
      checkOutput("div_done_cycle", 64'(doneAt), 64'd32);
      checkOutput("div_mflo_stalls", 64'(stalls), 64'd32);

      // MULT followed by independent ADDIUs
      applyStimulus(1'b1, I_MULT, 1'b0, 1'b0); advance();
      stalls = 0; busyCount = 0; doneAt = -1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, I_ADDIU, 1'b0, 1'b0);
         if (bus.id_ready !== 1'b1) stalls++;
         if (bus.md_busy === 1'b1) busyCount++;
         if (bus.md_done === 1'b1 && doneAt < 0) doneAt = i + 1;
         advance();
      end
      checkOutput("mult_addiu_stalls", 64'(stalls), 64'd0);
      checkOutput("mult_busy_cycles", 64'(busyCount), 64'd3);
      checkOutput("mult_done_cycle", 64'(doneAt), 64'd4);

      // SW held under a two-cycle external stall
      applyStimulus(1'b1, I_SW, 1'b1, 1'b0); advance();
      applyStimulus(1'b1, I_SW, 1'b1, 1'b0);
      checkOutput("sw_bubble1", 64'({bus.valid_pipe[0], bus.ctrl_pipe[13:0]}), 64'd0);
      advance();
      applyStimulus(1'b1, I_SW, 1'b0, 1'b0);
      checkOutput("sw_bubble2", 64'({bus.valid_pipe[0], bus.ctrl_pipe[13:0]}), 64'd0);
      advance();
      applyStimulus(1'b0, 32'b0, 1'b0, 1'b0);
      checkOutput("sw_slot0_valid", 64'(bus.valid_pipe[0]), 64'd1);
      checkOutput("sw_slot0_upper", 64'(bus.ctrl_pipe[13:4]), 64'(10'b0001010000));
      advance();

      // Unknown opcode 6'h3F
      applyStimulus(1'b1, I_BAD, 1'b0, 1'b0);
`ifdef MAINDEC_ILLEGAL_EXC_EN
      checkOutput("bad_illegal", 64'(bus.id_illegal), 64'd1);
      advance();
      applyStimulus(1'b0, 32'b0, 1'b0, 1'b0);
      checkOutput("bad_bubble", 64'({bus.valid_pipe[0], bus.ctrl_pipe[13:0]}), 64'd0);
      checkOutput("bad_exc_op", 64'(bus.exc_op), 64'h3F);
      checkOutput("bad_exc_flag", 64'(bus.exc_flag), 64'd1);
`else
      advance();
      applyStimulus(1'b0, 32'b0, 1'b0, 1'b0);
      checkOutput("bad_slot0", 64'({bus.valid_pipe[0], bus.ctrl_pipe[13:0]}), 64'h4000);
`endif
      advance();

      // Reset in the middle of a divide
      applyStimulus(1'b1, I_DIV, 1'b0, 1'b0); advance();
      for (int i = 0; i < 22; i++) begin
         applyStimulus(1'b0, 32'b0, 1'b0, 1'b0); advance();
      end
      applyStimulus(1'b0, 32'b0, 1'b0, 1'b1);
      checkOutput("rst_mid_busy_before", 64'(bus.md_busy), 64'd1);
      checkOutput("rst_mid_no_done", 64'(bus.md_done), 64'd0);
      advance();
      sawDone = 1'b0;
      applyStimulus(1'b0, 32'b0, 1'b0, 1'b0);
      checkOutput("rst_mid_busy_after", 64'(bus.md_busy), 64'd0);
      checkOutput("rst_mid_valid", 64'(bus.valid_pipe), 64'd0);
      advance();
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 32'b0, 1'b0, 1'b0);
         if (bus.md_done === 1'b1) sawDone = 1'b1;
         advance();
      end
      checkOutput("rst_mid_late_done", 64'(sawDone), 64'd0);

      for (int n = 0; n < 2500; n++) begin
         rIns = randInstr();
         applyStimulus(1'($urandom_range(99) < 85), rIns, 1'($urandom_range(99) < 15),
                       1'($urandom_range(199) == 0));
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
